// File: rtl/circle_rasterizer.sv
// Midpoint circle rasterizer. Accepts a centre/radius command and walks
// one octant of the circle with the midpoint error term, mirroring each
// (x,y) step into up to eight outline points or four horizontal fill
// spans. Every emitted point/span is offered on a registered ready/valid
// style output port (out_rts/out_rtr) that holds stable under backpressure.
module circle_rasterizer #(
  parameter int COORD_W = 10,
  parameter int COLOR_W = 12
) (
  input  logic               clk,
  input  logic               rst_,
  input  logic [COORD_W-1:0] x0_in,
  input  logic [COORD_W-1:0] y0_in,
  input  logic [COORD_W-1:0] r_in,
  input  logic [COLOR_W-1:0] color,
  input  logic               mode,
  input  logic [7:0]         octant_mask,
  input  logic               in_rts,
  output logic               in_rtr,
  output logic [COORD_W-1:0] out_xs,
  output logic [COORD_W-1:0] out_xe,
  output logic [COORD_W-1:0] out_y,
  output logic [COLOR_W-1:0] out_color,
  output logic               out_rts,
  input  logic               out_rtr,
  output logic               busy,
  output logic               done
);

  // Error term needs headroom beyond the coordinate width: it swings
  // between roughly -2r and +2r plus the step increments.
  localparam int ERR_W = COORD_W + 3;
  localparam logic signed [ERR_W-1:0] ONE = ERR_W'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EMIT = 2'd1,
    STEP = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Latched command and octant walk state
  logic [COORD_W-1:0]      x0, y0, x, y;
  logic [COORD_W-1:0]      x0_nxt, y0_nxt, x_nxt, y_nxt;
  logic signed [ERR_W-1:0] err, err_nxt;
  logic [2:0]              idx, idx_nxt;
  logic                    mode_q, mode_nxt;
  logic [7:0]              mask, mask_nxt;
  logic [COLOR_W-1:0]      color_nxt;

  // Step arithmetic, evaluated in a signed domain wide enough that x-1
  // going below zero (r=0) is seen as negative rather than wrapping.
  logic signed [ERR_W-1:0] x_ext, y_inc, x_dec, x_step;
  logic signed [ERR_W-1:0] err_keep, err_move;
  logic                    err_neg, step_exit;

  // Emission control
  logic       idx_en, advance;
  logic [2:0] last_idx;

  // Mirror one octant sample into the point/span selected by idx.
  // Returns {xs, xe, y}; all sums wrap modulo 2^COORD_W.
  function automatic logic [3*COORD_W-1:0] emit_span(
    input logic [COORD_W-1:0] cx,
    input logic [COORD_W-1:0] cy,
    input logic [COORD_W-1:0] px,
    input logic [COORD_W-1:0] py,
    input logic [2:0]         i,
    input logic               fill
  );
    logic [COORD_W-1:0] sx, ex, ry;
    sx = cx + px;
    ex = cx + px;
    ry = cy + py;
    if (fill) begin
      case (i[1:0])
        2'd0: begin sx = cx - px; ex = cx + px; ry = cy + py; end
        2'd1: begin sx = cx - px; ex = cx + px; ry = cy - py; end
        2'd2: begin sx = cx - py; ex = cx + py; ry = cy + px; end
        default: begin sx = cx - py; ex = cx + py; ry = cy - px; end
      endcase
    end else begin
      case (i)
        3'd0: begin sx = cx + px; ry = cy + py; end
        3'd1: begin sx = cx + py; ry = cy + px; end
        3'd2: begin sx = cx - py; ry = cy + px; end
        3'd3: begin sx = cx - px; ry = cy + py; end
        3'd4: begin sx = cx - px; ry = cy - py; end
        3'd5: begin sx = cx - py; ry = cy - px; end
        3'd6: begin sx = cx + py; ry = cy - px; end
        default: begin sx = cx + px; ry = cy - py; end
      endcase
      ex = sx;
    end
    return {sx, ex, ry};
  endfunction

  // Fill spans are always emitted; outline points obey the mask.
  function automatic logic idx_enabled(
    input logic       fill,
    input logic [7:0] m,
    input logic [2:0] i
  );
    return fill | m[i];
  endfunction

  assign in_rtr = (state == IDLE);
  assign busy   = (state != IDLE);

  assign x_ext     = $signed({3'b000, x});
  assign y_inc     = $signed({3'b000, y}) + ONE;
  assign x_dec     = x_ext - ONE;
  assign err_neg   = err[ERR_W-1];
  assign err_keep  = err + (y_inc <<< 1) + ONE;
  assign err_move  = err + ((y_inc - x_dec) <<< 1) + ONE;
  assign x_step    = err_neg ? x_ext : x_dec;
  assign step_exit = (x_step < y_inc);

  assign idx_en   = idx_enabled(mode_q, mask, idx);
  assign last_idx = mode_q ? 3'd3 : 3'd7;
  // A masked index consumes exactly one cycle; an enabled one waits for
  // the consumer to take it.
  assign advance  = idx_en ? (out_rts && out_rtr) : 1'b1;

  // Next-state, walk-state and completion pulse
  always_comb begin
    state_nxt = state;
    x0_nxt    = x0;
    y0_nxt    = y0;
    x_nxt     = x;
    y_nxt     = y;
    err_nxt   = err;
    idx_nxt   = idx;
    mode_nxt  = mode_q;
    mask_nxt  = mask;
    color_nxt = out_color;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (in_rts) begin
          x0_nxt    = x0_in;
          y0_nxt    = y0_in;
          mode_nxt  = mode;
          mask_nxt  = octant_mask;
          color_nxt = color;
          x_nxt     = r_in;
          y_nxt     = '0;
          err_nxt   = ONE - $signed({3'b000, r_in});
          idx_nxt   = 3'd0;
          state_nxt = EMIT;
        end
      end
      EMIT: begin
        if (advance) begin
          if (idx == last_idx) begin
            state_nxt = STEP;
          end else begin
            idx_nxt = idx + 3'd1;
          end
        end
      end
      STEP: begin
        y_nxt   = y + COORD_W'(1);
        x_nxt   = err_neg ? x : (x - COORD_W'(1));
        err_nxt = err_neg ? err_keep : err_move;
        idx_nxt = 3'd0;
        if (step_exit) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = EMIT;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Control registers: FSM state, emission index and output valid
  always_ff @(posedge clk) begin
    if (rst_) begin
      state   <= IDLE;
      idx     <= 3'd0;
      out_rts <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      out_rts <= (state_nxt == EMIT) && idx_enabled(mode_nxt, mask_nxt, idx_nxt);
    end
  end

  // Datapath registers: latched command, walk state and registered outputs
  // computed from the next-cycle walk state so they are valid the same
  // cycle out_rts rises and unchanged while a transfer is stalled.
  always_ff @(posedge clk) begin
    if (rst_) begin
      x0        <= '0;
      y0        <= '0;
      x         <= '0;
      y         <= '0;
      err       <= '0;
      mode_q    <= 1'b0;
      mask      <= '0;
      out_color <= '0;
      out_xs    <= '0;
      out_xe    <= '0;
      out_y     <= '0;
    end else begin
      x0        <= x0_nxt;
      y0        <= y0_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      err       <= err_nxt;
      mode_q    <= mode_nxt;
      mask      <= mask_nxt;
      out_color <= color_nxt;
      {out_xs, out_xe, out_y} <= emit_span(x0_nxt, y0_nxt, x_nxt, y_nxt, idx_nxt, mode_nxt);
    end
  end

endmodule

// File: tb/tb_circle_rasterizer.sv
// Scoreboard bench for circle_rasterizer: directed scenarios plus randomized
// commands with random output backpressure, checked against a plain-integer
// midpoint circle model.
module tb_circle_rasterizer;

  localparam int CW  = 10;
  localparam int KW  = 12;
  localparam int MSK = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_ = 1'b1;
  logic [CW-1:0] x0_in = '0, y0_in = '0, r_in = '0;
  logic [KW-1:0] color = '0;
  logic          mode = 1'b0;
  logic [7:0]    octant_mask = '0;
  logic          in_rts = 1'b0;
  logic          in_rtr;
  logic [CW-1:0] out_xs, out_xe, out_y;
  logic [KW-1:0] out_color;
  logic          out_rts;
  logic          out_rtr = 1'b1;
  logic          busy, done;

  circle_rasterizer #(.COORD_W(CW), .COLOR_W(KW)) dut (
    .clk(clk), .rst_(rst_),
    .x0_in(x0_in), .y0_in(y0_in), .r_in(r_in), .color(color),
    .mode(mode), .octant_mask(octant_mask),
    .in_rts(in_rts), .in_rtr(in_rtr),
    .out_xs(out_xs), .out_xe(out_xe), .out_y(out_y), .out_color(out_color),
    .out_rts(out_rts), .out_rtr(out_rtr),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int xs;
    int xe;
    int y;
    int col;
  } item_t;

  item_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    xfer_cnt = 0;
  int    rec_x[8];
  int    rec_y[8];
  int    last_x = 0, last_y = 0;
  logic  bp_en = 1'b0;
  logic  rtr_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic void push_item(input int xs, input int xe, input int y, input int col);
    item_t it;
    it.xs  = xs & MSK;
    it.xe  = xe & MSK;
    it.y   = y & MSK;
    it.col = col;
    exp_q.push_back(it);
  endfunction

  // Reference: walk the octant with integer midpoint arithmetic and list
  // every mirrored point or span in emission order.
  function automatic void model_cmd(input int x0, input int y0, input int r,
                                    input int fill, input int msk, input int col);
    int cx, cy, e;
    int px[8];
    int py[8];
    cx = r;
    cy = 0;
    e  = 1 - r;
    while (1) begin
      if (fill != 0) begin
        push_item(x0 - cx, x0 + cx, y0 + cy, col);
        push_item(x0 - cx, x0 + cx, y0 - cy, col);
        push_item(x0 - cy, x0 + cy, y0 + cx, col);
        push_item(x0 - cy, x0 + cy, y0 - cx, col);
      end else begin
        px = '{x0 + cx, x0 + cy, x0 - cy, x0 - cx, x0 - cx, x0 - cy, x0 + cy, x0 + cx};
        py = '{y0 + cy, y0 + cx, y0 + cx, y0 + cy, y0 - cy, y0 - cx, y0 - cx, y0 - cy};
        for (int i = 0; i < 8; i++)
          if (((msk >> i) & 1) != 0) push_item(px[i], px[i], py[i], col);
      end
      cy = cy + 1;
      if (e < 0) e = e + 2 * cy + 1;
      else begin
        cx = cx - 1;
        e  = e + 2 * (cy - cx) + 1;
      end
      if (cx < cy) break;
    end
  endfunction

  // Output ready driver: random backpressure or a forced level
  always @(posedge clk) begin
    #1;
    if (bp_en) out_rtr = ($urandom_range(0, 3) != 0);
    else       out_rtr = rtr_force;
  end

  // Monitor: pops the scoreboard on each transfer and checks stall stability
  logic          have_prev = 1'b0;
  logic [CW-1:0] p_xs, p_xe, p_y;
  always @(negedge clk) begin
    if (rst_) begin
      have_prev = 1'b0;
    end else begin
      if (have_prev)
        chk("stall_hold", {out_rts, out_xs, out_xe, out_y}, {1'b1, p_xs, p_xe, p_y});
      if (out_rts && out_rtr) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got xs=%0d xe=%0d y=%0d, required no output",
                   out_xs, out_xe, out_y);
        end else begin
          item_t it;
          it = exp_q.pop_front();
          chk("out_xs", out_xs, it.xs);
          chk("out_xe", out_xe, it.xe);
          chk("out_y", out_y, it.y);
          chk("out_color", out_color, it.col);
        end
        if (xfer_cnt < 8) begin
          rec_x[xfer_cnt] = out_xs;
          rec_y[xfer_cnt] = out_y;
        end
        last_x = out_xs;
        last_y = out_y;
        xfer_cnt++;
      end
      have_prev = out_rts && !out_rtr;
      p_xs = out_xs;
      p_xe = out_xe;
      p_y  = out_y;
    end
  end

  task automatic issue(input int x0, input int y0, input int r, input int fill,
                       input int msk, input int col);
    bit ok;
    @(posedge clk);
    #1;
    x0_in = CW'(x0); y0_in = CW'(y0); r_in = CW'(r);
    mode = fill[0]; octant_mask = msk[7:0]; color = KW'(col);
    in_rts = 1'b1;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_rtr) begin ok = 1; break; end
    end
    if (!ok) begin
      $display("FAIL accept_timeout: got in_rtr=0, required 1");
      $fatal(1, "command never accepted");
    end
    @(posedge clk);
    #1;
    in_rts = 1'b0;
    // Garbage on the command inputs while busy must be ignored
    x0_in = CW'($urandom); y0_in = CW'($urandom); r_in = CW'($urandom);
    color = KW'($urandom); mode = 1'($urandom); octant_mask = 8'($urandom);
    model_cmd(x0, y0, r, fill, msk, col);
  endtask

  // Counts cycles from acceptance to done; optional stall on the first point
  task automatic wait_done(input int stall, output int cyc, output logic rts1, output logic rtr1);
    bit got;
    got = 0;
    cyc = 0;
    rts1 = 1'b0;
    rtr1 = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin rts1 = out_rts; rtr1 = in_rtr; end
      if (stall != 0 && cyc == stall) rtr_force = 1'b1;
      if (done === 1'b1) begin got = 1; break; end
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL done_timeout: got no done in %0d cycles, required done", cyc);
    end
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("idle_rtr", in_rtr, 1);
    chk("busy_clear", busy, 0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   cyc;
    logic rts1, rtr1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_ = 1'b0;
    chk("rst_out_rts", out_rts, 0);
    chk("rst_in_rtr", in_rtr, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_pos", {out_xs, out_xe, out_y}, 0);
    chk("rst_out_color", out_color, 0);

    // Full outline, r=10
    xfer_cnt = 0;
    issue(100, 100, 10, 0, 8'hFF, 12'hABC);
    wait_done(0, cyc, rts1, rtr1);
    chk("outline_latency_rts", rts1, 1);
    chk("outline_busy_rtr", rtr1, 0);
    chk("outline_done_cycles", cyc, 72);
    chk("outline_points", xfer_cnt, 64);
    chk("outline_first", {rec_x[0], rec_y[0]}, {110, 100});
    chk("outline_last", {last_x, last_y}, {107, 93});

    // Single outline index enabled
    xfer_cnt = 0;
    issue(100, 100, 10, 0, 8'h01, 12'h123);
    wait_done(0, cyc, rts1, rtr1);
    chk("mask01_done_cycles", cyc, 72);
    chk("mask01_points", xfer_cnt, 8);
    chk("mask01_last", {last_x, last_y}, {107, 107});

    // Filled r=1
    xfer_cnt = 0;
    issue(100, 100, 1, 1, 8'h00, 12'h555);
    wait_done(0, cyc, rts1, rtr1);
    chk("fill_done_cycles", cyc, 5);
    chk("fill_spans", xfer_cnt, 4);
    chk("fill_last", {last_x, last_y}, {100, 99});

    // Backpressure on the first point for three cycles
    xfer_cnt = 0;
    rtr_force = 1'b0;
    issue(100, 100, 10, 0, 8'hFF, 12'h0F0);
    wait_done(3, cyc, rts1, rtr1);
    chk("stall_first_rts", rts1, 1);
    chk("stall_done_cycles", cyc, 75);
    chk("stall_points", xfer_cnt, 64);

    // Reset in the middle of emission, then a fresh r=0 command
    xfer_cnt = 0;
    issue(100, 100, 10, 0, 8'hFF, 12'hFFF);
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    rst_ = 1'b1;
    @(posedge clk);
    #1;
    rst_ = 1'b0;
    chk("midrst_out_rts", out_rts, 0);
    chk("midrst_in_rtr", in_rtr, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_color", out_color, 0);
    exp_q.delete();
    xfer_cnt = 0;
    issue(100, 100, 0, 0, 8'hFF, 12'h777);
    wait_done(0, cyc, rts1, rtr1);
    chk("r0_done_cycles", cyc, 9);
    chk("r0_points", xfer_cnt, 8);
    chk("r0_first", {rec_x[0], rec_y[0]}, {100, 100});
    chk("r0_last", {last_x, last_y}, {100, 100});

    // Coordinate wrap below zero
    xfer_cnt = 0;
    issue(5, 5, 10, 0, 8'hFF, 12'h321);
    wait_done(0, cyc, rts1, rtr1);
    chk("wrap_idx0", {rec_x[0], rec_y[0]}, {15, 5});
    chk("wrap_idx3", {rec_x[3], rec_y[3]}, {1019, 5});

    // Randomized commands with random backpressure
    bp_en = 1'b1;
    for (int n = 0; n < 15; n++) begin
      issue(int'($urandom_range(0, MSK)), int'($urandom_range(0, MSK)),
            int'($urandom_range(0, 30)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 255)), int'($urandom_range(0, 4095)));
      wait_done(0, cyc, rts1, rtr1);
    end
    bp_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
